// File: rtl/dpram_sync_param.sv
// Single-clock true dual-port RAM with collision flag and optional output stage.
// Define DPRAM_INIT_CLEAR_EN to zero the whole array after every reset.
module dpram_sync_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RD_MODE = 0,
    parameter int PRIO_A  = 1,
    parameter int PIPE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] data_i_a,
    output logic [DATA_W-1:0] data_o_a,
    input  logic              enb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] data_i_b,
    output logic [DATA_W-1:0] data_o_b,
    output logic              ready,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_ready;
    logic [DATA_W-1:0] r_qa1;
    logic [DATA_W-1:0] r_qb1;
    logic              r_coll1;

    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_wr_a;
    logic              w_wr_b;
    logic              w_same;
    logic              w_coll;
    logic              w_keep_a;
    logic              w_keep_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    always_comb begin
        w_acc_a  = ena & r_ready;
        w_acc_b  = enb & r_ready;
        w_wr_a   = w_acc_a & wea;
        w_wr_b   = w_acc_b & web;
        w_same   = (addra == addrb);
        w_coll   = w_wr_a & w_wr_b & w_same;
        w_keep_a = w_wr_a & ~(w_coll & (PRIO_A == 0));
        w_keep_b = w_wr_b & ~(w_coll & (PRIO_A != 0));
        w_rd_a   = r_mem[addra];
        w_rd_b   = r_mem[addrb];
        // Write-first: a same-address write on either port wins over stored data
        if (RD_MODE != 0) begin
            if (w_wr_b && w_same && (!w_wr_a || PRIO_A == 0))
                w_rd_a = data_i_b;
            else if (w_wr_a)
                w_rd_a = data_i_a;
            if (w_wr_a && w_same && (!w_wr_b || PRIO_A != 0))
                w_rd_b = data_i_a;
            else if (w_wr_b)
                w_rd_b = data_i_b;
        end
    end

`ifdef DPRAM_INIT_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
        end else begin
            unique case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN:   r_ready <= 1'b1;
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign w_clr_we   = (r_state == S_CLEAR) & ~rst;
    assign w_clr_addr = r_clr_addr;
`else
    always_ff @(posedge clk) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // Storage is never reset; only the clear engine (if built) zeroes it
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_keep_a) r_mem[addra] <= data_i_a;
            if (w_keep_b) r_mem[addrb] <= data_i_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qa1   <= '0;
            r_qb1   <= '0;
            r_coll1 <= 1'b0;
        end else begin
            if (w_acc_a) r_qa1 <= w_rd_a;
            if (w_acc_b) r_qb1 <= w_rd_b;
            r_coll1 <= w_coll;
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic [DATA_W-1:0] r_qa2;
            logic [DATA_W-1:0] r_qb2;
            logic              r_coll2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_qa2   <= '0;
                    r_qb2   <= '0;
                    r_coll2 <= 1'b0;
                end else begin
                    r_qa2   <= r_qa1;
                    r_qb2   <= r_qb1;
                    r_coll2 <= r_coll1;
                end
            end

            assign data_o_a  = r_qa2;
            assign data_o_b  = r_qb2;
            assign collision = r_coll2;
        end else begin : g_nopipe
            assign data_o_a  = r_qa1;
            assign data_o_b  = r_qb1;
            assign collision = r_coll1;
        end
    endgenerate

    assign ready = r_ready;

endmodule

// File: tb/tb_dpram_sync_param.sv
// Bench for dpram_sync_param: two configurations driven in lockstep and
// checked against an array-based reference of the access rules.
module tb_dpram_sync_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, wea, enb, web;
    logic [7:0]  addra, addrb;
    logic [15:0] dia, dib;
    logic [15:0] qa0, qb0, qa1, qb1;
    logic        rdy0, rdy1, col0, col1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpram_sync_param #(
        .DATA_W(16), .ADDR_W(8), .RD_MODE(0), .PRIO_A(1), .PIPE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .data_i_a(dia), .data_o_a(qa0),
        .enb(enb), .web(web), .addrb(addrb), .data_i_b(dib), .data_o_b(qb0),
        .ready(rdy0), .collision(col0)
    );

    dpram_sync_param #(
        .DATA_W(16), .ADDR_W(4), .RD_MODE(1), .PRIO_A(0), .PIPE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra[3:0]), .data_i_a(dia), .data_o_a(qa1),
        .enb(enb), .web(web), .addrb(addrb[3:0]), .data_i_b(dib), .data_o_b(qb1),
        .ready(rdy1), .collision(col1)
    );

`ifdef DPRAM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    localparam int P_AW   [2] = '{8, 4};
    localparam int P_RD   [2] = '{0, 1};
    localparam int P_PA   [2] = '{1, 0};
    localparam int P_PIPE [2] = '{0, 1};

    // Reference: word array, known flags, and recent port results by age
    logic [15:0] mm [2][256];
    bit          mv [2][256];
    logic [15:0] ha [2][2];
    logic [15:0] hb [2][2];
    bit          ka [2][2];
    bit          kb [2][2];
    bit          hc [2][2];
    int          ne [2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        int          msk, aa, ab, lat;
        bit          rdy, acc_a, acc_b, wa, wb, same, coll;
        logic [15:0] va, vb, win;
        bit          kva, kvb;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ha[i][k] = '0; hb[i][k] = '0;
                ka[i][k] = 1'b1; kb[i][k] = 1'b1;
                hc[i][k] = 1'b0;
            end
            ne[i] = 0;
            if (CLR)
                for (int k = 0; k < 256; k++) begin
                    mm[i][k] = '0;
                    mv[i][k] = 1'b1;
                end
            return;
        end
        msk   = (1 << P_AW[i]) - 1;
        lat   = CLR ? (1 << P_AW[i]) : 1;
        rdy   = (ne[i] >= lat);
        aa    = int'(addra) & msk;
        ab    = int'(addrb) & msk;
        acc_a = ena && rdy;
        acc_b = enb && rdy;
        wa    = acc_a && wea;
        wb    = acc_b && web;
        same  = (aa == ab);
        coll  = wa && wb && same;
        win   = (P_PA[i] != 0) ? dia : dib;
        va = mm[i][aa]; kva = mv[i][aa];
        vb = mm[i][ab]; kvb = mv[i][ab];
        if (P_RD[i] != 0) begin
            if (coll) begin
                va = win; kva = 1'b1; vb = win; kvb = 1'b1;
            end else begin
                if (wa)               begin va = dia; kva = 1'b1; end
                else if (wb && same)  begin va = dib; kva = 1'b1; end
                if (wb)               begin vb = dib; kvb = 1'b1; end
                else if (wa && same)  begin vb = dia; kvb = 1'b1; end
            end
        end
        ha[i][1] = ha[i][0]; ka[i][1] = ka[i][0];
        hb[i][1] = hb[i][0]; kb[i][1] = kb[i][0];
        hc[i][1] = hc[i][0]; hc[i][0] = coll;
        if (acc_a) begin ha[i][0] = va; ka[i][0] = kva; end
        if (acc_b) begin hb[i][0] = vb; kb[i][0] = kvb; end
        if (coll) begin
            mm[i][aa] = win; mv[i][aa] = 1'b1;
        end else begin
            if (wa) begin mm[i][aa] = dia; mv[i][aa] = 1'b1; end
            if (wb) begin mm[i][ab] = dib; mv[i][ab] = 1'b1; end
        end
        ne[i]++;
    endtask

    task automatic step();
        int          lat, p;
        logic [15:0] oa, ob;
        logic        orr, oc;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int i = 0; i < 2; i++) begin
            lat = CLR ? (1 << P_AW[i]) : 1;
            p   = P_PIPE[i];
            oa  = (i == 0) ? qa0 : qa1;
            ob  = (i == 0) ? qb0 : qb1;
            orr = (i == 0) ? rdy0 : rdy1;
            oc  = (i == 0) ? col0 : col1;
            chk($sformatf("ready%0d", i), 64'(orr), 64'(!rst && ne[i] >= lat));
            chk($sformatf("coll%0d", i), 64'(oc), 64'(hc[i][p]));
            if (ka[i][p]) chk($sformatf("qa%0d", i), 64'(oa), 64'(ha[i][p]));
            if (kb[i][p]) chk($sformatf("qb%0d", i), 64'(ob), 64'(hb[i][p]));
        end
    endtask

    task automatic drive(input logic ea, input logic wa_, input int aa,
                         input int da, input logic eb, input logic wb_,
                         input int ab, input int db);
        ena = ea; wea = wa_; addra = 8'(aa); dia = 16'(da);
        enb = eb; web = wb_; addrb = 8'(ab); dib = 16'(db);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("rst_qa0", 64'(qa0), 64'd0);
        chk("rst_rdy0", 64'(rdy0), 64'd0);
        rst = 1'b0;
        repeat (CLR ? 260 : 2) step();

        for (int i = 0; i < 128; i++) begin
            drive(1, 1, i, $urandom, 1, 1, i + 128, $urandom);
            step();
        end

        drive(1, 1, 0, 9, 1, 1, 1, 10);
        step();
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        step();
        chk("basic_a", 64'(qa0), 64'd10);
        chk("basic_b", 64'(qb0), 64'd9);

        drive(1, 1, 2, 7, 1, 1, 2, 8);
        step();
        chk("dual_wr_flag", 64'(col0), 64'd1);
        drive(1, 0, 2, 0, 1, 0, 2, 0);
        step();
        chk("dual_wr_flag_end", 64'(col0), 64'd0);
        chk("dual_wr_win", 64'(qa0), 64'd7);

        drive(1, 1, 4, 6, 0, 0, 0, 0);
        step();
        drive(1, 1, 4, 5, 1, 0, 4, 0);
        step();
        chk("rdw_old", 64'(qb0), 64'd6);
        drive(0, 0, 0, 0, 1, 0, 4, 0);
        step();
        chk("rdw_after", 64'(qb0), 64'd5);

        drive(1, 1, 3, 16'h00AA, 0, 0, 0, 0);
        step();
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (11) step();
        chk("hold_a", 64'(qa0), 64'h00AA);

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1) == 0)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7), $urandom,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7), $urandom);
            else
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 255), $urandom,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 255), $urandom);
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
